// File: rtl/pwm_peripheral.sv
// Drives 16 user pins low, high, or from one shared PWM waveform.
// Duty changes are latched only at the period boundary so no runt pulses appear.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_sync
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_shadow_q, duty_shadow_d;
  logic [15:0]   out_q, out_d;
  logic          pwm_sync_q, pwm_sync_d;

  logic          tick;
  logic          period_end;
  logic          pwm_raw;
  logic [15:0]   en_o;
  logic [15:0]   en_p;

  always_comb begin
    en_o = {en_reg_out_15_8, en_reg_out_7_0};
    en_p = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    tick       = (prescaler_q == PW'(CLK_DIV - 1));
    period_end = tick && (pwm_cnt_q == 8'hFF);

    prescaler_d   = tick ? '0 : prescaler_q + PW'(1);
    pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_shadow_d = period_end ? pwm_duty_cycle : duty_shadow_q;
    pwm_sync_d    = period_end;

    // 0xFF is special-cased so full duty never shows a low count at 255.
    pwm_raw = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);

    // Output enable dominates; PWM select only picks waveform vs constant high.
    out_d = en_o & (~en_p | {16{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      pwm_cnt_q     <= 8'h00;
      duty_shadow_q <= 8'h00;
      out_q         <= 16'h0000;
      pwm_sync_q    <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_shadow_q <= duty_shadow_d;
      out_q         <= out_d;
      pwm_sync_q    <= pwm_sync_d;
    end
  end

  assign out      = out_q;
  assign pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle scoreboard on the default instance plus
// per-period high-time measurements, and a CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_pwm_peripheral;

  localparam int DIV = 13;
  localparam int P   = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out;
  logic        sync;
  logic [15:0] out1;
  logic        sync1;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] sb[$];

  always #50 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .out(out), .pwm_sync(sync)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(8'h01), .en_reg_out_15_8(8'h00),
    .en_reg_pwm_7_0(8'h01), .en_reg_pwm_15_8(8'h00),
    .pwm_duty_cycle(8'h01), .out(out1), .pwm_sync(sync1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: position in the period counted from reset release; duty taken
  // from the value present at the clock that ends each period.
  initial begin
    int k;
    logic [7:0] shadow;
    k = 0;
    shadow = 8'h00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        shadow = 8'h00;
      end else begin
        int pos;
        int cnt;
        logic raw;
        logic [15:0] e;
        pos = k % P;
        cnt = pos / DIV;
        raw = (shadow == 8'hFF) || (cnt < int'(shadow));
        for (int i = 0; i < 16; i++)
          e[i] = en_out[i] ? (en_pwm[i] ? raw : 1'b1) : 1'b0;
        sb.push_back({pos == P - 1, e});
        if (pos == P - 1) shadow = duty;
        k++;
      end
    end
  end

  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        check("in_reset", {16'h0, out}, 32'h0);
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out", {16'h0, out}, {16'h0, e[15:0]});
        check("sync", {31'h0, sync}, {31'h0, e[16]});
      end
    end
  end

  task automatic wait_sync();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * P && !found; i++) begin
      @(negedge clk);
      if (sync) found = 1'b1;
    end
    check("wait_sync", {31'h0, found}, 32'h1);
  endtask

  // Counts one period starting just after a sync sample; optionally changes duty mid-way.
  task automatic measure(input int change_at, input logic [7:0] new_duty,
                         output int len, output int h0, output int h4, output int h8);
    logic done;
    len = 0; h0 = 0; h4 = 0; h8 = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * P && !done; i++) begin
      @(negedge clk);
      len++;
      h0 += int'(out[0]);
      h4 += int'(out[4]);
      h8 += int'(out[8]);
      if (i == change_at) duty = new_duty;
      if (sync) done = 1'b1;
    end
  endtask

  task automatic period(input string tag, input int change_at, input logic [7:0] new_duty,
                        input int exp_h0);
    int len, h0, h4, h8;
    measure(change_at, new_duty, len, h0, h4, h8);
    check({tag, "_len"}, len, P);
    check({tag, "_pin0_high"}, h0, exp_h0);
    check({tag, "_pin4_high"}, h4, P);
    check({tag, "_pin8_high"}, h8, 0);
    $display("period %s: len=%0d pin0_high=%0d pin4_high=%0d pin8_high=%0d", tag, len, h0, h4, h8);
  endtask

  initial begin
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_sync", {31'h0, sync}, 32'h0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    check("first_edge", {16'h0, out}, 32'h0000FFFF);

    en_out = 16'h00FF;
    en_pwm = 16'h0F0F;
    duty   = 8'h80;
    wait_sync();
    period("duty80", -1, 8'h00, 1664);
    period("duty80_buffered", 0, 8'h00, 1664);
    period("duty00", 0, 8'hFF, 0);
    period("dutyFF", 0, 8'h40, P);
    period("duty40_mid_change", 1500, 8'hC0, 832);
    period("dutyC0", -1, 8'h00, 2496);

    duty = 8'h80;
    repeat (1000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_clear", {16'h0, out}, 32'h0);
    repeat (2) @(negedge clk);
    #5 rst_n = 1'b1;
    begin
      int len, h0, h4;
      logic done;
      len = 0; h0 = 0; h4 = 0;
      done = 1'b0;
      for (int i = 0; i < 2 * P && !done; i++) begin
        @(negedge clk);
        len++;
        h0 += int'(out[0]);
        h4 += int'(out[4]);
        if (sync) done = 1'b1;
      end
      check("post_reset_len", len, P);
      check("post_reset_pin0_high", h0, 0);
      check("post_reset_pin4_high", h4, P);
      $display("post-reset period: len=%0d pin0_high=%0d pin4_high=%0d", len, h0, h4);
    end
    period("resumed80", -1, 8'h80, 1664);

    begin
      int len, h;
      logic found, done;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
        @(negedge clk);
        if (sync1) found = 1'b1;
      end
      check("div1_wait_sync", {31'h0, found}, 32'h1);
      len = 0; h = 0;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
        @(negedge clk);
        len++;
        h += int'(out1[0]);
        check("div1_other_pins", {17'h0, out1[15:1]}, 32'h0);
        if (sync1) done = 1'b1;
      end
      check("div1_len", len, 256);
      check("div1_pin0_high", h, 1);
      $display("div1 period: len=%0d pin0_high=%0d", len, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
